// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [6:0]             opcode;
    logic                   zero;
    logic [1:0]             ALU_op;
    logic [1:0]             ALU_src_a;
    logic [1:0]             ALU_src_b;
    logic [1:0]             result_src;
    logic                   adr_src;
    logic                   ir_write;
    logic                   pc_write;
    logic                   reg_write;
    logic                   mem_write;
    logic                   illegal;
    logic                   halted;
    logic [COUNT_WIDTH-1:0] instr_count;
    modport master (
        input  opcode, zero,
        output ALU_op, ALU_src_a, ALU_src_b, result_src, adr_src, ir_write,
               pc_write, reg_write, mem_write, illegal, halted, instr_count
    );
    modport slave (
        output opcode, zero,
        input  ALU_op, ALU_src_a, ALU_src_b, result_src, adr_src, ir_write,
               pc_write, reg_write, mem_write, illegal, halted, instr_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I multicycle main control FSM plus retired-instruction counter.
// Define MULTICYCLE_CONTROLLER_HALT_EN to add a sticky HALT state entered on ecall/ebreak.
module multicycle_controller #(
    parameter int COUNT_WIDTH = 32
) (
    input logic                    clock,
    input logic                    reset,
    multicycle_controller_if.master bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
        , HALT
`endif
    } state_t;

    state_t state, state_next;
    logic [COUNT_WIDTH-1:0] count;
    logic [1:0] alu_op, src_a, src_b, res_src;
    logic adr, irw, pc_update, branch, rw, mw, ill;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
            count <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH) count <= count + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_next = FETCH;
        alu_op = 2'b00;
        src_a = 2'b00;
        src_b = 2'b00;
        res_src = 2'b00;
        adr = 1'b0;
        irw = 1'b0;
        pc_update = 1'b0;
        branch = 1'b0;
        rw = 1'b0;
        mw = 1'b0;
        ill = 1'b0;
        case (state)
            FETCH: begin
                irw = 1'b1;
                src_b = 2'b10;
                res_src = 2'b10;
                pc_update = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXECUTER;
                    OP_I:              state_next = EXECUTEI;
                    OP_BRANCH:         state_next = BEQ;
                    OP_JAL:            state_next = JAL;
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
                    OP_SYSTEM:         state_next = HALT;
`endif
                    default:           ill = 1'b1;
                endcase
            end
            MEMADR: begin
                src_a = 2'b10;
                src_b = 2'b01;
                state_next = (bus.opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                res_src = 2'b01;
                rw = 1'b1;
            end
            MEMWRITE: begin
                adr = 1'b1;
                mw = 1'b1;
            end
            EXECUTER: begin
                src_a = 2'b10;
                alu_op = 2'b10;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                src_a = 2'b10;
                src_b = 2'b01;
                alu_op = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: rw = 1'b1;
            BEQ: begin
                src_a = 2'b10;
                alu_op = 2'b01;
                branch = 1'b1;
            end
            JAL: begin
                src_a = 2'b01;
                src_b = 2'b10;
                pc_update = 1'b1;
                state_next = ALUWB;
            end
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
            HALT: state_next = HALT;
`endif
            default: state_next = FETCH;
        endcase
    end

    // reset masks every output so nothing fires while an instruction is being aborted
    assign bus.ALU_op      = reset ? 2'b00 : alu_op;
    assign bus.ALU_src_a   = reset ? 2'b00 : src_a;
    assign bus.ALU_src_b   = reset ? 2'b00 : src_b;
    assign bus.result_src  = reset ? 2'b00 : res_src;
    assign bus.adr_src     = ~reset & adr;
    assign bus.ir_write    = ~reset & irw;
    assign bus.pc_write    = ~reset & (pc_update | (branch & bus.zero));
    assign bus.reg_write   = ~reset & rw;
    assign bus.mem_write   = ~reset & mw;
    assign bus.illegal     = ~reset & ill;
    assign bus.instr_count = reset ? '0 : count;

`ifdef MULTICYCLE_CONTROLLER_HALT_EN
    logic halted_q;
    always_ff @(posedge clock) begin
        if (reset) halted_q <= 1'b0;
        else halted_q <= halted_q | (state_next == HALT);
    end
    assign bus.halted = ~reset & halted_q;
`else
    assign bus.halted = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction stream checked against a per-instruction
// table of expected control words and a retired-instruction count model.
module tb_multicycle_controller;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if #(.COUNT_WIDTH(32)) bus ();
    multicycle_controller #(.COUNT_WIDTH(32)) dut (.clock(clk), .reset(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] ref_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // word = {ALU_op, src_a, src_b, result_src, adr_src, ir_write, pc_write, reg_write, mem_write, illegal, halted}
    function automatic logic [14:0] w(input int aop, input int sa, input int sb, input int rs,
                                      input int adr, input int ir, input int pcw, input int rw,
                                      input int mw, input int ill);
        return {2'(aop), 2'(sa), 2'(sb), 2'(rs), 1'(adr), 1'(ir), 1'(pcw), 1'(rw), 1'(mw), 1'(ill), 1'b0};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.ALU_op, bus.ALU_src_a, bus.ALU_src_b, bus.result_src, bus.adr_src, bus.ir_write,
                bus.pc_write, bus.reg_write, bus.mem_write, bus.illegal, bus.halted};
    endfunction

    function automatic bit legal(input logic [6:0] op);
        return op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL};
    endfunction

    function automatic int cpi(input logic [6:0] op);
        case (op)
            OP_LOAD:                          return 5;
            OP_STORE, OP_R, OP_I, OP_JAL:     return 4;
            OP_BRANCH:                        return 3;
            default:                          return 2;
        endcase
    endfunction

    // expected control word in cycle k of an instruction (k=0 is FETCH)
    function automatic logic [14:0] expected(input logic [6:0] op, input int k, input logic z);
        logic [14:0] alu_wb;
        alu_wb = w(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        if (k == 0) return w(0, 0, 2, 2, 0, 1, 1, 0, 0, 0);
        if (k == 1) return w(0, 1, 1, 0, 0, 0, 0, 0, 0, legal(op) ? 0 : 1);
        case (op)
            OP_LOAD:   return k == 2 ? w(0, 2, 1, 0, 0, 0, 0, 0, 0, 0) :
                              k == 3 ? w(0, 0, 0, 0, 1, 0, 0, 0, 0, 0) : w(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
            OP_STORE:  return k == 2 ? w(0, 2, 1, 0, 0, 0, 0, 0, 0, 0) : w(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
            OP_R:      return k == 2 ? w(2, 2, 0, 0, 0, 0, 0, 0, 0, 0) : alu_wb;
            OP_I:      return k == 2 ? w(2, 2, 1, 0, 0, 0, 0, 0, 0, 0) : alu_wb;
            OP_BRANCH: return w(1, 2, 0, 0, 0, 0, z ? 1 : 0, 0, 0, 0);
            OP_JAL:    return k == 2 ? w(0, 1, 2, 0, 0, 0, 1, 0, 0, 0) : alu_wb;
            default:   return '0;
        endcase
    endfunction

    // runs one instruction from its FETCH cycle; zsel 0/1 fixes zero, 2 randomizes it each cycle;
    // abort_at >= 0 asserts reset during that cycle instead of completing
    task automatic run_instr(input logic [6:0] op, input int zsel, input int abort_at);
        for (int k = 0; k < cpi(op); k++) begin
            if (k == 0) bus.opcode = op;
            bus.zero = (zsel == 2) ? 1'($urandom) : 1'(zsel);
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check($sformatf("abort op=%b k=%0d ctl", op, k), 32'(obs()), 32'd0);
                check("abort count", bus.instr_count, 32'd0);
                @(posedge clk);
                #1 rst = 1'b0;
                ref_count = '0;
                return;
            end
            @(negedge clk);
            check($sformatf("op=%b k=%0d ctl", op, k), 32'(obs()), 32'(expected(op, k, bus.zero)));
            check($sformatf("op=%b k=%0d count", op, k), bus.instr_count, ref_count);
            if (k == 0) ref_count++;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] rand_illegal();
        logic [6:0] op;
        do op = 7'($urandom); while (legal(op) || op == OP_SYSTEM);
        return op;
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] pool [6];
        int r;
        pool = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL};
        r = $urandom_range(0, 7);
        if (r < 6) return pool[r];
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
        return rand_illegal();
`else
        return r == 7 ? OP_SYSTEM : rand_illegal();
`endif
    endfunction

    initial begin
        bus.opcode = 7'($urandom);
        bus.zero = 1'b1;
        ref_count = '0;
        repeat (2) begin
            @(negedge clk);
            check("reset ctl", 32'(obs()), 32'd0);
            check("reset count", bus.instr_count, 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(OP_LOAD, 2, -1);
        run_instr(OP_STORE, 2, -1);
        run_instr(OP_R, 2, -1);
        run_instr(OP_I, 2, -1);
        run_instr(OP_BRANCH, 1, -1);
        run_instr(OP_BRANCH, 0, -1);
        run_instr(OP_JAL, 2, -1);
        run_instr(7'b1111111, 2, -1);
`ifndef MULTICYCLE_CONTROLLER_HALT_EN
        run_instr(OP_SYSTEM, 2, -1);
`endif
        for (int i = 0; i < 80; i++) run_instr(rand_op(), 2, -1);
        run_instr(OP_STORE, 2, 3);
        run_instr(OP_LOAD, 2, -1);
        run_instr(OP_R, 2, 2);
        for (int i = 0; i < 20; i++) run_instr(rand_op(), 2, -1);
`ifdef MULTICYCLE_CONTROLLER_HALT_EN
        bus.opcode = OP_SYSTEM;
        for (int k = 0; k < 2; k++) begin
            bus.zero = 1'($urandom);
            @(negedge clk);
            check($sformatf("ecall k=%0d ctl", k), 32'(obs()),
                  32'(k == 0 ? w(0, 0, 2, 2, 0, 1, 1, 0, 0, 0) : w(0, 1, 1, 0, 0, 0, 0, 0, 0, 0)));
            if (k == 0) ref_count++;
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 10; k++) begin
            bus.zero = 1'($urandom);
            bus.opcode = 7'($urandom);
            @(negedge clk);
            check("halt ctl", 32'(obs()), 32'd1);
            check("halt count", bus.instr_count, ref_count);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        ref_count = '0;
        run_instr(OP_JAL, 2, -1);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
